// File: rtl/lcd_db_in.sv
// Avalon-MM input port for LCD data/busy lines: 2-flop synchronizer, optional per-bit debounce
// (enabled by defining LCD_DB_IN_DEBOUNCE_EN), edge capture with write-1-to-clear and a masked level irq.
module lcd_db_in #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned EDGE_TYPE    = 0,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

`ifdef LCD_DB_IN_DEBOUNCE_EN
  localparam int unsigned ArmLen = 3 + DEBOUNCE_CNT;
`else
  localparam int unsigned ArmLen = 3;
`endif
  localparam int unsigned ArmW = $clog2(ArmLen + 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] data_in, data_in_d, data_prev;
  logic [WIDTH-1:0] edge_det, edge_pend;
  logic [WIDTH-1:0] irqmask, edgecapture, edgecapture_d;
  logic [WIDTH-1:0] rd_mux;
  logic [ArmW-1:0]  arm_cnt;
  logic             armed;
  logic             wr_en, rd_en;

  assign armed = (arm_cnt == ArmW'(ArmLen));
  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

`ifdef LCD_DB_IN_DEBOUNCE_EN
  logic [7:0] db_cnt [WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (reset) begin
        db_cnt[i] <= '0;
      end else if (sync2[i] != data_in[i]) begin
        if (db_cnt[i] == 8'(DEBOUNCE_CNT - 1)) db_cnt[i] <= '0;
        else                                   db_cnt[i] <= db_cnt[i] + 8'd1;
      end else begin
        db_cnt[i] <= '0;
      end
    end
  end

  always_comb begin
    data_in_d = data_in;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2[i] != data_in[i] && db_cnt[i] == 8'(DEBOUNCE_CNT - 1)) data_in_d[i] = sync2[i];
    end
  end
`else
  assign data_in_d = sync2;
`endif

  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == 0)      edge_det = data_in & ~data_prev;
    else if (EDGE_TYPE == 1) edge_det = ~data_in & data_prev;
    else                     edge_det = data_in ^ data_prev;
  end

  // A new edge on a bit wins over a simultaneous write-1-clear of that bit.
  always_comb begin
    edgecapture_d = edgecapture;
    if (wr_en && address == 2'd3) edgecapture_d = edgecapture & ~writedata;
    edgecapture_d = edgecapture_d | edge_pend;
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0:    rd_mux = data_in;
      2'd1:    rd_mux = '0;
      2'd2:    rd_mux = irqmask;
      default: rd_mux = edgecapture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      data_in     <= '0;
      data_prev   <= '0;
      edge_pend   <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      arm_cnt     <= '0;
    end else begin
      sync1       <= in_port;
      sync2       <= sync1;
      data_in     <= data_in_d;
      // While disarmed, data_prev tracks the incoming value so the level settling
      // after reset never looks like an edge.
      data_prev   <= armed ? data_in : data_in_d;
      edge_pend   <= armed ? edge_det : '0;
      edgecapture <= edgecapture_d;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      if (wr_en && address == 2'd2) irqmask <= writedata;
      if (rd_en) readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
